// File: rtl/wand_arb_pkg.sv
// Shared definitions for the wired-AND arbitrating transmitter.
package wand_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEND   = 2'd1,
        ST_LISTEN = 2'd2,
        ST_DONE   = 2'd3
    } arb_state_t;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_BIT_TICKS = 4;

    // Counter width that still works for a count range of one.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wand_bit_timer.sv
// Bit timing for wand_arb_tx: tick counter with a last-tick strobe and a
// bit-index down-counter that starts at WIDTH-1 on load.
module wand_bit_timer
    import wand_arb_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int BIT_TICKS = DEF_BIT_TICKS
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic run,
    output logic last_tick,
    output logic last_bit
);

    localparam int TW = cnt_width(BIT_TICKS);
    localparam int BW = cnt_width(WIDTH);
    localparam logic [TW-1:0] TICK_LAST = TW'(BIT_TICKS - 1);
    localparam logic [BW-1:0] BIT_FIRST = BW'(WIDTH - 1);

    logic [TW-1:0] tick_reg;
    logic [BW-1:0] bit_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_reg <= '0;
            bit_reg  <= '0;
        end else if (load) begin
            tick_reg <= '0;
            bit_reg  <= BIT_FIRST;
        end else if (run) begin
            if (tick_reg == TICK_LAST) begin
                tick_reg <= '0;
                if (bit_reg != '0)
                    bit_reg <= bit_reg - BW'(1);
            end else begin
                tick_reg <= tick_reg + TW'(1);
            end
        end else begin
            // Parked at zero whenever no frame is being timed.
            tick_reg <= '0;
            bit_reg  <= '0;
        end
    end

    assign last_tick = run && (tick_reg == TICK_LAST);
    assign last_bit  = (bit_reg == '0);

endmodule

// File: rtl/wand_arb_tx.sv
// Wired-AND bitwise-arbitrating frame transmitter: sends MSB first, backs off
// on a lost recessive bit, flags a dominant bit read back as recessive.
module wand_arb_tx
    import wand_arb_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int BIT_TICKS = DEF_BIT_TICKS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    input  logic             bus_in,
    output logic             bus_drv,
    output logic             busy,
    output logic             done,
    output logic             won,
    output logic             lost,
    output logic             err,
    output logic [WIDTH-1:0] rx_data
);

    arb_state_t       state_reg;
    logic [WIDTH-1:0] tx_reg;
    logic [WIDTH-1:0] rx_reg;
    logic [WIDTH-1:0] tx_shl;
    logic [WIDTH-1:0] rx_shl;
    logic             bus_drv_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             won_reg;
    logic             lost_reg;
    logic             err_reg;

    logic accept;
    logic run;
    logic sample;
    logic last_bit;

    assign accept = (state_reg == ST_IDLE) && start && bus_in;
    assign run    = (state_reg == ST_SEND) || (state_reg == ST_LISTEN);
    assign tx_shl = tx_reg << 1;
    assign rx_shl = WIDTH'({rx_reg, bus_in});

    wand_bit_timer #(
        .WIDTH     (WIDTH),
        .BIT_TICKS (BIT_TICKS)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .run       (run),
        .last_tick (sample),
        .last_bit  (last_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            tx_reg      <= '0;
            rx_reg      <= '0;
            bus_drv_reg <= 1'b1;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            won_reg     <= 1'b0;
            lost_reg    <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            won_reg  <= 1'b0;
            lost_reg <= 1'b0;
            err_reg  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    bus_drv_reg <= 1'b1;
                    if (accept) begin
                        tx_reg      <= data;
                        rx_reg      <= '0;
                        bus_drv_reg <= data[WIDTH-1];
                        busy_reg    <= 1'b1;
                        state_reg   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (sample) begin
                        rx_reg <= rx_shl;
                        if (!bus_drv_reg && bus_in) begin
                            // Our dominant bit did not reach the line: abort.
                            bus_drv_reg <= 1'b1;
                            busy_reg    <= 1'b0;
                            done_reg    <= 1'b1;
                            err_reg     <= 1'b1;
                            state_reg   <= ST_DONE;
                        end else if (bus_drv_reg && !bus_in) begin
                            bus_drv_reg <= 1'b1;
                            if (last_bit) begin
                                busy_reg  <= 1'b0;
                                done_reg  <= 1'b1;
                                lost_reg  <= 1'b1;
                                state_reg <= ST_DONE;
                            end else begin
                                state_reg <= ST_LISTEN;
                            end
                        end else if (last_bit) begin
                            bus_drv_reg <= 1'b1;
                            busy_reg    <= 1'b0;
                            done_reg    <= 1'b1;
                            won_reg     <= 1'b1;
                            state_reg   <= ST_DONE;
                        end else begin
                            tx_reg      <= tx_shl;
                            bus_drv_reg <= tx_shl[WIDTH-1];
                        end
                    end
                end
                ST_LISTEN: begin
                    bus_drv_reg <= 1'b1;
                    if (sample) begin
                        rx_reg <= rx_shl;
                        if (last_bit) begin
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            lost_reg  <= 1'b1;
                            state_reg <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    bus_drv_reg <= 1'b1;
                    busy_reg    <= 1'b0;
                    state_reg   <= ST_IDLE;
                end
                default: begin
                    bus_drv_reg <= 1'b1;
                    busy_reg    <= 1'b0;
                    state_reg   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus_drv = bus_drv_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;
    assign won     = won_reg;
    assign lost    = lost_reg;
    assign err     = err_reg;
    assign rx_data = rx_reg;

endmodule

// File: tb/tb_wand_arb_tx.sv
// Directed bench for wand_arb_tx: a bit-level frame model predicts every
// output each cycle; literal expectations pin the model's key results.
module tb_wand_arb_tx;

    localparam int W  = 8;
    localparam int BT = 4;
    localparam int M_LONE = 0;
    localparam int M_COMP = 1;
    localparam int M_ST1  = 2;
    localparam int M_ST0  = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] data;
    logic         bus_in;
    logic         bus_drv;
    logic         busy;
    logic         done;
    logic         won;
    logic         lost;
    logic         err;
    logic [W-1:0] rx_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t0    = 0;
    int bus_mode = M_LONE;
    logic [W-1:0] comp_data = '1;
    logic comp_bit;
    bit frame_active = 0;
    bit chk_en = 0;
    logic [W-1:0] rx_hold = '0;

    // Model results for the current frame
    logic [W-1:0] m_drv;
    logic [W-1:0] m_rx;
    int m_out;       // 0 won, 1 lost, 2 err
    int m_done_rel;

    // Observed at done
    int obs_done_rel = -1;
    logic obs_won, obs_lost, obs_err;
    logic [W-1:0] obs_rx;

    wand_arb_tx #(.WIDTH(W), .BIT_TICKS(BT)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .data    (data),
        .bus_in  (bus_in),
        .bus_drv (bus_drv),
        .busy    (busy),
        .done    (done),
        .won     (won),
        .lost    (lost),
        .err     (err),
        .rx_data (rx_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        comp_bit = 1'b1;
        if (frame_active && (cyc - t0) >= 1 && (cyc - t0) <= W * BT)
            comp_bit = comp_data[W - 1 - ((cyc - t0) - 1) / BT];
    end

    always_comb begin
        case (bus_mode)
            M_LONE:  bus_in = bus_drv;
            M_COMP:  bus_in = bus_drv & comp_bit;
            M_ST1:   bus_in = 1'b1;
            default: bus_in = 1'b0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Walk the frame bit by bit as the wired-AND line would resolve it.
    task automatic model_frame(input logic [W-1:0] d, input int mode, input logic [W-1:0] comp);
        bit   lost_m;
        logic nd, bv;
        int   end_bit;
        lost_m  = 0;
        end_bit = 0;
        m_out   = 0;
        m_rx    = '0;
        m_drv   = '1;
        for (int k = W - 1; k >= 0; k--) begin
            nd = lost_m ? 1'b1 : d[k];
            case (mode)
                M_LONE:  bv = nd;
                M_COMP:  bv = nd & comp[k];
                M_ST1:   bv = 1'b1;
                default: bv = 1'b0;
            endcase
            m_drv[k] = nd;
            m_rx = {m_rx[W-2:0], bv};
            if (!lost_m && !nd && bv) begin
                m_out   = 2;
                end_bit = k;
                break;
            end
            if (!lost_m && nd && !bv)
                lost_m = 1;
        end
        if (m_out != 2 && lost_m)
            m_out = 1;
        m_done_rel = (W - end_bit) * BT + 1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            int   rel;
            logic e_busy, e_drv, e_done, e_won, e_lost, e_err;
            logic [W-1:0] e_rx;
            bit   rx_chk;
            rel    = cyc - t0;
            e_busy = 0; e_drv = 1; e_done = 0; e_won = 0; e_lost = 0; e_err = 0;
            e_rx   = rx_hold;
            rx_chk = 1;
            if (frame_active && rel >= 1) begin
                if (rel < m_done_rel) begin
                    e_busy = 1;
                    e_drv  = m_drv[W - 1 - (rel - 1) / BT];
                    rx_chk = 0;
                end else if (rel == m_done_rel) begin
                    e_done = 1;
                    e_won  = (m_out == 0);
                    e_lost = (m_out == 1);
                    e_err  = (m_out == 2);
                    e_rx   = m_rx;
                end else begin
                    e_rx = m_rx;
                end
            end
            check("busy", busy, e_busy);
            check("bus_drv", bus_drv, e_drv);
            check("done", done, e_done);
            check("won", won, e_won);
            check("lost", lost, e_lost);
            check("err", err, e_err);
            if (rx_chk)
                check("rx_data", rx_data, e_rx);
            if (done === 1'b1 && frame_active && obs_done_rel < 0) begin
                obs_done_rel = rel;
                obs_won  = won;
                obs_lost = lost;
                obs_err  = err;
                obs_rx   = rx_data;
            end
        end
    end

    task automatic begin_frame(input logic [W-1:0] d, input int mode, input logic [W-1:0] comp);
        model_frame(d, mode, comp);
        bus_mode     = mode;
        comp_data    = comp;
        obs_done_rel = -1;
        start        = 1'b1;
        data         = d;
        t0           = cyc;
        frame_active = 1;
        @(posedge clk); #1;
        start = 1'b0;
        data  = W'($urandom);
    endtask

    task automatic finish_frame(input int inj_rel, input logic [W-1:0] inj_data);
        int n;
        n = 0;
        while (obs_done_rel < 0 && n < 200) begin
            if (cyc - t0 == inj_rel) begin
                start = 1'b1;
                data  = inj_data;
            end
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end
        check("done_seen", (obs_done_rel >= 0), 1'b1);
        frame_active = 0;
        rx_hold      = m_rx;
        $display("frame mode=%0d done_rel=%0d won=%b lost=%b err=%b rx=%h",
                 bus_mode, obs_done_rel, obs_won, obs_lost, obs_err, obs_rx);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        data  = '0;
        @(posedge clk); #1;
        chk_en = 1;
        check("reset_drv", bus_drv, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_rx", rx_data, 8'h00);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Lone node
        begin_frame(8'hA5, M_LONE, 8'hFF);
        finish_frame(-1, 8'h00);
        check("lone_done_rel", obs_done_rel, 33);
        check("lone_won", obs_won, 1'b1);
        check("lone_rx", obs_rx, 8'hA5);

        // Competitor wins at bit 5
        begin_frame(8'hA5, M_COMP, 8'h95);
        finish_frame(-1, 8'h00);
        check("comp_done_rel", obs_done_rel, 33);
        check("comp_lost", obs_lost, 1'b1);
        check("comp_rx", obs_rx, 8'h95);

        // Stuck recessive line: error on first dominant bit
        begin_frame(8'h7F, M_ST1, 8'hFF);
        finish_frame(-1, 8'h00);
        check("err_done_rel", obs_done_rel, 5);
        check("err_flag", obs_err, 1'b1);
        check("err_won", obs_won, 1'b0);

        // Start refused while the line is dominant
        bus_mode = M_ST0;
        start    = 1'b1;
        data     = 8'h3C;
        repeat (4) @(posedge clk);
        #1;
        start = 1'b0;
        check("refused_busy", busy, 1'b0);
        $display("refused start busy=%b bus_drv=%b", busy, bus_drv);
        bus_mode = M_LONE;
        @(posedge clk); #1;

        // Reset in the middle of bit 6, then a normal frame
        begin_frame(8'hA5, M_LONE, 8'hFF);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst          = 1'b0;
        frame_active = 0;
        rx_hold      = '0;
        check("abort_drv", bus_drv, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_rx", rx_data, 8'h00);
        $display("reset abort bus_drv=%b busy=%b", bus_drv, busy);
        @(posedge clk); #1;
        begin_frame(8'h3C, M_LONE, 8'hFF);
        finish_frame(-1, 8'h00);
        check("post_rst_won", obs_won, 1'b1);
        check("post_rst_rx", obs_rx, 8'h3C);

        // Start during SEND is ignored
        begin_frame(8'hC3, M_LONE, 8'hFF);
        finish_frame(10, 8'h5A);
        check("ign_done_rel", obs_done_rel, 33);
        check("ign_rx", obs_rx, 8'hC3);

        // Arbitration lost on the very last bit
        begin_frame(8'h01, M_COMP, 8'h00);
        finish_frame(-1, 8'h00);
        check("lastbit_lost", obs_lost, 1'b1);
        check("lastbit_rx", obs_rx, 8'h00);

        // Error on the very last bit
        begin_frame(8'hFE, M_ST1, 8'hFF);
        finish_frame(-1, 8'h00);
        check("lastbit_err_rel", obs_done_rel, 33);
        check("lastbit_err", obs_err, 1'b1);

        // Node wins against a weaker competitor
        begin_frame(8'h12, M_COMP, 8'h3F);
        finish_frame(-1, 8'h00);
        check("win_comp", obs_won, 1'b1);
        check("win_comp_rx", obs_rx, 8'h12);

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wand_arb_tx.md
WAND_ARB_TX -- requirements
Module: wand_arb_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 8: frame length in bits.
REQ-002 SHALL have parameter BIT_TICKS, default 4, minimum 2: clk cycles per bit.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: request to transmit data.
REQ-006 SHALL have port data, input, WIDTH bits: frame to send, MSB first, captured on an accepted start.
REQ-007 SHALL have port bus_in, input, 1 bit: resolved wired-AND line value, synchronous to clk.
REQ-008 SHALL have port bus_drv, output, 1 bit: this node's driver onto the wand net (0 dominant, 1 recessive/released).
REQ-009 SHALL have port busy, output, 1 bit: high in SEND and LISTEN.
REQ-010 SHALL have port done, output, 1 bit: one-cycle end-of-frame pulse.
REQ-011 SHALL have port won, output, 1 bit: valid with done; the whole frame was sent without loss or error.
REQ-012 SHALL have port lost, output, 1 bit: valid with done; arbitration was lost.
REQ-013 SHALL have port err, output, 1 bit: valid with done; the node drove dominant but read recessive.
REQ-014 SHALL have port rx_data, output, WIDTH bits: bits sampled from the bus during the frame; stable from done until the next accepted start.

Function
REQ-015 SHALL implement states IDLE, SEND, LISTEN and DONE.
REQ-016 In IDLE, start=1 with bus_in=1 SHALL be accepted: load data, clear rx_data, set bit index WIDTH-1, clear tick count, and enter SEND.
REQ-017 In IDLE, start=1 with bus_in=0 SHALL be ignored: no state change, bus_drv stays 1.
REQ-018 start SHALL be ignored in SEND, LISTEN and DONE.
REQ-019 With start accepted on edge T, each bit SHALL occupy BIT_TICKS cycles; bit k is cycles T+1+(WIDTH-1-k)*BIT_TICKS onward.
REQ-020 In SEND, bus_drv SHALL equal the current data bit.
REQ-021 In LISTEN, DONE and IDLE, bus_drv SHALL be 1.
REQ-022 bus_in SHALL be sampled on the last tick of each bit and shifted into the rx_data LSB.
REQ-023 If a SEND sample finds bus_drv=1 and bus_in=0, the FSM SHALL enter LISTEN and set lost.
REQ-024 In LISTEN, sampling SHALL continue for the remaining bits.
REQ-025 If a SEND sample finds bus_drv=0 and bus_in=1, the FSM SHALL enter DONE immediately with err=1; rx_data then holds the partial frame.
REQ-026 After the bit-0 sample, SEND and LISTEN SHALL enter DONE.
REQ-027 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-028 Nominal latency: done SHALL be high on cycle T+WIDTH*BIT_TICKS+1.
REQ-029 won, lost and err SHALL be mutually exclusive and 0 whenever done=0.

Reset
REQ-030 When rst=1 at an edge, the next cycle SHALL have state IDLE, bus_drv=1, busy=0, done=0, won=0, lost=0, err=0, rx_data=0, and bit and tick counters at 0.
REQ-031 rst SHALL take priority over start and abort any frame in progress, releasing the bus within one cycle.

Structure
REQ-032 The state encoding and the default WIDTH and BIT_TICKS constants SHALL live in shared package wand_arb_pkg.
REQ-033 Bit timing SHALL be a sub-module wand_bit_timer (tick counter with a last-tick strobe and a bit-index down-counter); the FSM, shift registers and flags SHALL stay in wand_arb_tx.

Verification (WIDTH=8, BIT_TICKS=4, start accepted on cycle 0)
REQ-034 Lone node with bus_in=bus_drv and data=8'hA5 -> done on cycle 33, won=1, rx_data=8'hA5.
REQ-035 Competitor wired-AND drives 8'h95 while the node sends 8'hA5 -> lost set at the bit-5 sample, bus_drv=1 from bit 4 onward, done on cycle 33 with lost=1 and rx_data=8'h95.
REQ-036 bus_in stuck at 1 while the node sends 8'h7F -> done on cycle 5 with err=1 and won=0.
REQ-037 start with bus_in=0 in IDLE -> no busy, bus_drv stays 1, no done.
REQ-038 rst pulsed in the middle of bit 6 -> next cycle bus_drv=1, busy=0, all flags 0; a following start completes normally.
REQ-039 start pulsed during SEND with different data -> ignored; the original frame completes unchanged.
